// File: rtl/ro_meter_pkg.sv
// Shared FSM state type, default timing constants and width helpers for the
// ring-oscillator frequency meter.
package ro_meter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        LATCH  = 2'd3
    } meter_state_t;

    localparam int DEF_GATE_CYCLES   = 50000;
    localparam int DEF_SETTLE_CYCLES = 4;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Down-counter width able to hold the longer of the two load values (span-1).
    function automatic int timer_width(input int gate, input int settle);
        int span;
        span = (gate > settle) ? gate : settle;
        return (span <= 2) ? 1 : $clog2(span);
    endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchroniser for an asynchronous ring-oscillator output followed by
// a rising-edge detector (one pulse per 0->1 seen in the fpga_clk1 domain).
module ro_edge_sync (
    input  logic fpga_clk1,
    input  logic reset,
    input  logic din,
    output logic rise
);

    // sync[1:0] is the metastability chain, sync[2] is the previous sample
    logic [2:0] sync;

    always_ff @(posedge fpga_clk1) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], din};
        end
    end

    assign rise = sync[1] & ~sync[2];

endmodule

// File: rtl/ro_freq_meter.sv
// Multi-channel ring-oscillator frequency meter: counts synchronised rising edges
// over a fixed gate window. Define RO_FREQ_AVG_EN for per-channel averaged results.
//
// state  | meaning
// IDLE   | not measuring, waiting for enable
// SETTLE | channel mux just switched, edges ignored while synchroniser flushes
// GATE   | counting edges for GATE_CYCLES cycles
// LATCH  | result strobe cycle, counter cleared, pick next channel
module ro_freq_meter
    import ro_meter_pkg::*;
#(
    parameter int  N_CH          = 4,
    parameter int  CNT_W         = 16,
    parameter int  GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int  SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    localparam int CH_W          = ch_width(N_CH)
) (
    input  logic             fpga_clk1,
    input  logic             reset,
    input  logic             enable,
    input  logic             scan_mode,
    input  logic [CH_W-1:0]  chan_sel,
    input  logic [N_CH-1:0]  ring_in,
    output logic [CNT_W-1:0] value_out,
    output logic [CH_W-1:0]  value_ch,
    output logic             value_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int               TMR_W       = timer_width(GATE_CYCLES, SETTLE_CYCLES);
    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(N_CH - 1);

    meter_state_t     state;
    logic [CH_W-1:0]  ch;
    logic [CH_W-1:0]  sel_clamped;
    logic [CH_W-1:0]  ch_scan_next;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] result;
    logic             ovf;
    logic             ovf_next;
    logic             ring_mux;
    logic             rise;
    logic             timer_done;
    logic             latch_now;

    assign ring_mux = ring_in[ch];

    ro_edge_sync u_edge_sync (
        .fpga_clk1 (fpga_clk1),
        .reset     (reset),
        .din       (ring_mux),
        .rise      (rise)
    );

    assign timer_done = (timer == '0);
    assign latch_now  = (state == GATE) && enable && timer_done;

    always_comb begin
        sel_clamped = chan_sel;
        if (int'({1'b0, chan_sel}) >= N_CH) begin
            sel_clamped = '0;
        end
        ch_scan_next = (ch == CH_LAST) ? '0 : ch + CH_W'(1);
    end

    // Saturating count including this cycle's edge, so the last GATE cycle counts.
    always_comb begin
        count_next = count;
        ovf_next   = ovf;
        if (rise) begin
            if (count == CNT_MAX) begin
                ovf_next = 1'b1;
            end else begin
                count_next = count + CNT_W'(1);
            end
        end
    end

`ifdef RO_FREQ_AVG_EN
    logic [CNT_W-1:0]        avg [N_CH];
    logic [N_CH-1:0]         avg_init;
    logic signed [CNT_W:0]   avg_diff;
    logic [CNT_W-1:0]        avg_next;

    // Exponential average with weight 1/4; first result on a channel seeds it.
    always_comb begin
        avg_diff = $signed({1'b0, count_next}) - $signed({1'b0, avg[ch]});
        avg_next = count_next;
        if (avg_init[ch]) begin
            avg_next = avg[ch] + CNT_W'(avg_diff >>> 2);
        end
    end

    always_ff @(posedge fpga_clk1) begin
        if (reset) begin
            avg_init <= '0;
            for (int i = 0; i < N_CH; i++) begin
                avg[i] <= '0;
            end
        end else if (latch_now) begin
            avg[ch]      <= avg_next;
            avg_init[ch] <= 1'b1;
        end
    end

    assign result = avg_next;
`else
    assign result = count_next;
`endif

    always_ff @(posedge fpga_clk1) begin
        if (reset) begin
            state       <= IDLE;
            ch          <= '0;
            timer       <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            value_out   <= '0;
            value_ch    <= '0;
            value_valid <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= SETTLE;
                        ch    <= scan_mode ? '0 : sel_clamped;
                        timer <= SETTLE_LOAD;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        count <= '0;
                        ovf   <= 1'b0;
                    end else if (timer_done) begin
                        state <= GATE;
                        timer <= GATE_LOAD;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                GATE: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        count <= '0;
                        ovf   <= 1'b0;
                    end else if (timer_done) begin
                        state       <= LATCH;
                        value_out   <= result;
                        value_ch    <= ch;
                        overflow    <= ovf_next;
                        value_valid <= 1'b1;
                        count       <= '0;
                        ovf         <= 1'b0;
                    end else begin
                        timer <= timer - TMR_W'(1);
                        count <= count_next;
                        ovf   <= ovf_next;
                    end
                end
                LATCH: begin
                    if (enable) begin
                        state <= SETTLE;
                        ch    <= scan_mode ? ch_scan_next : sel_clamped;
                        timer <= SETTLE_LOAD;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
